uart_rx_memory_writer: RTL and testbench

//  UART receive front end directly upstream of the shared receive memory. Samples the serial line,

---
 rtl/uart_rx_memory_writer.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx_memory_writer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_memory_writer.sv
// UART 8N1 receiver that packs bytes LSB-byte-first into words and writes them to a circular buffer.
// Optional UART_RX_PARITY_EN selects 8E1 framing and adds parity_error_out.
module uart_rx_memory_writer #(
  parameter int unsigned CLKS_PER_BIT  = 434,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     enable_in,
  input  logic                     rx_in,
  output logic                     memory_wr_out,
  output logic [ADDRESS_WIDTH-1:0] write_address_out,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     byte_valid_out,
  output logic                     framing_error_out
`ifdef UART_RX_PARITY_EN
  ,
  output logic                     parity_error_out
`endif
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BC_W-1:0]  BC_LAST   = BC_W'(BYTES - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4, S_WRITE = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3, S_WRITE = 3'd4
  } state_e;
`endif

  state_e                   state_q, state_d;
  logic                     rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [2:0]               bit_idx_q, bit_idx_d;
  logic [7:0]               shift_q, shift_d;
  logic [DATA_WIDTH-1:0]    word_q, word_d;
  logic [BC_W-1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     wr_q, wr_d;
  logic                     byte_valid_q, byte_valid_d;
  logic                     ferr_q, ferr_d;
  logic                     bit_done;
`ifdef UART_RX_PARITY_EN
  logic                     par_bad_q, par_bad_d;
  logic                     perr_q, perr_d;
`endif

  assign bit_done = (cnt_q == BIT_LAST);

  // Synchronizer; rx_prev_q gives the falling-edge reference for start detection.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      byte_cnt_q   <= '0;
      ptr_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      wr_q         <= 1'b0;
      byte_valid_q <= 1'b0;
      ferr_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      perr_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
      ptr_q        <= ptr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wr_q         <= wr_d;
      byte_valid_q <= byte_valid_d;
      ferr_q       <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      perr_q       <= perr_d;
`endif
    end
  end

  // Frame FSM; every sample point after START lands at mid-bit.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    ptr_d        = ptr_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wr_d         = 1'b0;
    byte_valid_d = 1'b0;
    ferr_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    perr_d       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (enable_in && rx_prev_q && !rx_sync_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = S_STOP;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          cnt_d     = '0;
          par_bad_d = (^shift_q) != rx_sync_q;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!rx_sync_q) begin
            ferr_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_bad_q) begin
            perr_d = 1'b1;
          end
`endif
          else begin
            byte_valid_d = 1'b1;
            for (int unsigned l = 0; l < BYTES; l++) begin
              if (byte_cnt_q == BC_W'(l)) word_d[l*8 +: 8] = shift_q;
            end
            if (byte_cnt_q == BC_LAST) begin
              wr_d    = 1'b1;
              addr_d  = ptr_q;
              data_d  = word_d;
              state_d = S_WRITE;
            end else begin
              byte_cnt_d = byte_cnt_q + BC_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        ptr_d      = ptr_q + ADDRESS_WIDTH'(1);
        byte_cnt_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign memory_wr_out     = wr_q;
  assign write_address_out = addr_q;
  assign data_out          = data_q;
  assign byte_valid_out    = byte_valid_q;
  assign framing_error_out = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error_out  = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_memory_writer.sv
// Scoreboard bench for uart_rx_memory_writer: directed scenarios followed by random frames.
// Stimulus queues expected events and writes; a negedge monitor pops and compares them.
module tb_uart_rx_memory_writer;
  localparam int C  = 16;
  localparam int AW = 5;
  localparam int DW = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b1;
  logic          rx  = 1'b1;
  logic          memory_wr_out;
  logic [AW-1:0] write_address_out;
  logic [DW-1:0] data_out;
  logic          byte_valid_out;
  logic          framing_error_out;
`ifdef UART_RX_PARITY_EN
  logic          parity_error_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Expected event codes: 1 byte accepted, 2 framing error, 3 parity error.
  int  exp_ev[$];
  wr_t exp_wr[$];

  // Reference model of buffer state.
  int         m_ptr = 0;
  int         m_cnt = 0;
  logic [7:0] m_bytes [2];

  // Monitor observations.
  int            wr_count = 0, bv_count = 0, fe_count = 0, pe_count = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;

  uart_rx_memory_writer #(
    .CLKS_PER_BIT (C),
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .clock_in         (clk),
    .reset_in         (rst),
    .enable_in        (en),
    .rx_in            (rx),
    .memory_wr_out    (memory_wr_out),
    .write_address_out(write_address_out),
    .data_out         (data_out),
    .byte_valid_out   (byte_valid_out),
    .framing_error_out(framing_error_out)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_error_out (parity_error_out)
`endif
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void pop_ev(input string name, input int code);
    if (exp_ev.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got unexpected pulse expected none", name);
    end else begin
      check(name, exp_ev.pop_front(), code);
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int  w;
    wr_t e;
    m_bytes[m_cnt] = b;
    m_cnt++;
    if (m_cnt == DW / 8) begin
      w      = int'(m_bytes[0]) + 256 * int'(m_bytes[1]);
      e.addr = AW'(m_ptr);
      e.data = DW'(w);
      exp_wr.push_back(e);
      m_ptr  = (m_ptr + 1) % (1 << AW);
      m_cnt  = 0;
    end
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      st_addr = '0;
      st_data = '0;
    end else begin
      if (byte_valid_out) begin
        bv_count++;
        pop_ev("byte_valid", 1);
      end
      if (framing_error_out) begin
        fe_count++;
        pop_ev("framing_error", 2);
      end
`ifdef UART_RX_PARITY_EN
      if (parity_error_out) begin
        pe_count++;
        pop_ev("parity_error", 3);
      end
`endif
      if (memory_wr_out) begin
        wr_count++;
        last_addr = write_address_out;
        last_data = data_out;
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", write_address_out, data_out);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 32'(write_address_out), 32'(e.addr));
          check("wr_data", 32'(data_out), 32'(e.data));
          st_addr = e.addr;
          st_data = e.data;
        end
      end else begin
        check("addr_stable", 32'(write_address_out), 32'(st_addr));
        check("data_stable", 32'(data_out), 32'(st_data));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    check("pending_ev_at_reset", exp_ev.size(), 0);
    check("pending_wr_at_reset", exp_wr.size(), 0);
    rst = 1'b1;
    rx  = 1'b1;
    tick(2);
    check("rst_wr", 32'(memory_wr_out), 0);
    check("rst_addr", 32'(write_address_out), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_bv", 32'(byte_valid_out), 0);
    check("rst_fe", 32'(framing_error_out), 0);
`ifdef UART_RX_PARITY_EN
    check("rst_pe", 32'(parity_error_out), 0);
`endif
    m_ptr = 0;
    m_cnt = 0;
    rst   = 1'b0;
    tick(2);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                            input int stop_len, input bit expect_it);
    if (expect_it) begin
      if (!stop_ok) exp_ev.push_back(2);
`ifdef UART_RX_PARITY_EN
      else if (!par_ok) exp_ev.push_back(3);
`endif
      else begin
        exp_ev.push_back(1);
        model_byte(b);
      end
    end
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(C);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ ~par_ok;
    tick(C);
`endif
    rx = stop_ok;
    tick(stop_len);
    if (!stop_ok) begin
      rx = 1'b1;
      tick(C);
    end
  endtask

  initial begin
    int c0, f0, b0;
    logic [7:0] b;
    bit so, po;

    do_reset();

    // Two bytes form one word at address 0.
    c0 = wr_count;
    send_frame(8'h34, 1, 1, C, 1);
    send_frame(8'h12, 1, 1, C, 1);
    tick(C);
    check("t1_writes", wr_count - c0, 1);
    check("t1_addr", 32'(last_addr), 0);
    check("t1_data", 32'(last_data), 32'h1234);

    // Framing error discards the byte without advancing the lane.
    do_reset();
    c0 = wr_count;
    f0 = fe_count;
    send_frame(8'h55, 0, 1, C, 1);
    send_frame(8'hCD, 1, 1, C, 1);
    send_frame(8'hAB, 1, 1, C, 1);
    tick(C);
    check("t2_ferr", fe_count - f0, 1);
    check("t2_writes", wr_count - c0, 1);
    check("t2_addr", 32'(last_addr), 0);
    check("t2_data", 32'(last_data), 32'hABCD);

    // Short low glitch is rejected, receiver still usable afterwards.
    c0 = wr_count;
    f0 = fe_count;
    b0 = bv_count;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(3 * C);
    check("t3_bv", bv_count - b0, 0);
    check("t3_fe", fe_count - f0, 0);
    check("t3_wr", wr_count - c0, 0);
    send_frame(8'h5A, 1, 1, C, 1);
    tick(C);
    check("t3_recover_bv", bv_count - b0, 1);

    // 66 bytes: 33 writes wrapping back to address 0.
    do_reset();
    c0 = wr_count;
    for (int k = 0; k < 66; k++) send_frame(8'(k), 1, 1, C, 1);
    tick(C);
    check("t4_writes", wr_count - c0, 33);
    check("t4_addr", 32'(last_addr), 0);
    check("t4_data", 32'(last_data), 32'h4140);

    // Reset during bit 3 of the second byte of a word.
    send_frame(8'h11, 1, 1, C, 1);
    tick(C);
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(32'h22 >> i);
      tick(C);
    end
    tick(C / 2);
    do_reset();
    tick(2 * C);
    c0 = wr_count;
    send_frame(8'h78, 1, 1, C, 1);
    send_frame(8'h56, 1, 1, C, 1);
    tick(C);
    check("t5_writes", wr_count - c0, 1);
    check("t5_addr", 32'(last_addr), 0);
    check("t5_data", 32'(last_data), 32'h5678);

`ifdef UART_RX_PARITY_EN
    // Bad parity rejected, good parity accepted.
    f0 = pe_count;
    b0 = bv_count;
    send_frame(8'h07, 1, 0, C, 1);
    tick(C);
    check("t6_perr", pe_count - f0, 1);
    check("t6_rejected", bv_count - b0, 0);
    send_frame(8'h07, 1, 1, C, 1);
    tick(C);
    check("t6_accepted", bv_count - b0, 1);
`endif

    // Disabled receiver ignores a frame; dropping enable mid-frame still completes it.
    b0 = bv_count;
    f0 = fe_count;
    en = 1'b0;
    tick(C);
    send_frame(8'h96, 1, 1, C, 0);
    tick(2 * C);
    check("t7_idle_bv", bv_count - b0, 0);
    check("t7_idle_fe", fe_count - f0, 0);
    en = 1'b1;
    tick(C);
    fork
      send_frame(8'hC3, 1, 1, C, 1);
      begin
        tick(3 * C);
        en = 1'b0;
      end
    join
    tick(C);
    check("t7_midframe_bv", bv_count - b0, 1);
    en = 1'b1;
    tick(C);

    // Random frames, random errors, shortened stop bits and gaps.
    for (int n = 0; n < 120; n++) begin
      b  = 8'($urandom_range(0, 255));
      so = ($urandom_range(0, 7) != 0);
      po = ($urandom_range(0, 7) != 0);
      send_frame(b, so, po, $urandom_range(12, 16), 1);
      tick($urandom_range(0, 10));
    end

    tick(3 * C);
    check("ev_queue_drained", exp_ev.size(), 0);
    check("wr_queue_drained", exp_wr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
